// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a single-entry output buffer
// for decode, and redirect handling that drops any response still in flight.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4
);

    typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    // Low bits of the redirect target are forced to zero, so they are never read.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^RedirectPC[1:0];

    // Issue only when the output buffer is empty or drains this cycle.
    assign ImemReq    = (state_q == StReq) && !Redirect && !reset && (!valid_q || InstrReady);
    assign ImemAddr   = pc_q;
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign PCOut      = pc_out_q;
    assign PCPlus4    = pc_out_q + 32'd4;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;

        if (Redirect) begin
            pc_d    = {RedirectPC[31:2], 2'b00};
            valid_d = 1'b0;
            unique case (state_q)
                StReq:   state_d = StReq;
                StWait:  state_d = ImemRValid ? StReq : StDrop;
                StDrop:  state_d = StDrop;
                default: state_d = StReq;
            endcase
        end else begin
            if (valid_q && InstrReady) begin
                valid_d = 1'b0;
            end
            unique case (state_q)
                StReq: begin
                    if (ImemReq && ImemGnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = StWait;
                    end
                end
                StWait: begin
                    if (ImemRValid) begin
                        instr_d  = ImemRData;
                        pc_out_d = req_pc_q;
                        valid_d  = 1'b1;
                        state_d  = StReq;
                    end
                end
                StDrop: begin
                    if (ImemRValid) begin
                        state_d = StReq;
                    end
                end
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StReq;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
            instr_q  <= NopInstr;
            pc_out_q <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-by-cycle vector table plus short hand-written
// sequences for reset-in-flight and PC wrap-around.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        gnt, rvalid, ready, redir;
    logic [31:0] rdata, rpc;

    logic        req0, valid0, req1, valid1;
    logic [31:0] addr0, instr0, pcout0, pcp40;
    logic [31:0] addr1, instr1, pcout1, pcp41;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .reset(reset), .ImemReq(req0), .ImemAddr(addr0), .ImemGnt(gnt),
        .ImemRValid(rvalid), .ImemRData(rdata), .Redirect(redir), .RedirectPC(rpc),
        .InstrValid(valid0), .InstrReady(ready), .Instr(instr0), .PCOut(pcout0),
        .PCPlus4(pcp40)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(reset), .ImemReq(req1), .ImemAddr(addr1), .ImemGnt(gnt),
        .ImemRValid(rvalid), .ImemRData(rdata), .Redirect(redir), .RedirectPC(rpc),
        .InstrValid(valid1), .InstrReady(ready), .Instr(instr1), .PCOut(pcout1),
        .PCPlus4(pcp41)
    );

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic g, input logic v, input logic [31:0] d, input logic rd,
                       input logic re, input logic [31:0] rp, input logic er,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep);
        vec_t t;
        t = '{gnt: g, rv: v, rdata: d, ready: rd, redir: re, rpc: rp, e_req: er, e_addr: ea,
              e_valid: ev, e_instr: ei, e_pc: ep};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic g, input logic v, input logic [31:0] d, input logic rd,
                         input logic re, input logic [31:0] rp);
        gnt = g; rvalid = v; rdata = d; ready = rd; redir = re; rpc = rp;
    endtask

    localparam logic [31:0] Nop = 32'h0000_0013;
    localparam logic [31:0] A0 = 32'h0010_0093, A1 = 32'h0020_0113, A2 = 32'h0031_8193;
    localparam logic [31:0] Dead = 32'hDEAD_BEEF, Bad = 32'hBAD0_0BAD, C0 = 32'h4020_8233;

    initial begin
        // gnt rv rdata ready redir rpc | req addr valid instr pcout
        add(1, 0, 0,    1, 0, 0,         1, 32'h0,   0, Nop, 32'h0);
        add(1, 1, A0,   1, 0, 0,         0, 32'h4,   0, Nop, 32'h0);
        add(1, 0, 0,    1, 0, 0,         1, 32'h4,   1, A0,  32'h0);
        add(1, 1, A1,   1, 0, 0,         0, 32'h8,   0, A0,  32'h0);
        add(1, 0, 0,    1, 0, 0,         1, 32'h8,   1, A1,  32'h4);
        add(1, 1, A2,   1, 0, 0,         0, 32'hC,   0, A1,  32'h4);
        // decode stalls for 5 cycles: buffer holds, no request
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 32'hC, 1, A2, 32'h8);
        add(1, 0, 0,    1, 0, 0,         1, 32'hC,   1, A2,  32'h8);
        // redirect while waiting; response shows up two cycles later and is dropped
        add(0, 0, 0,    1, 1, 32'h100,   0, 32'h10,  0, A2,  32'h8);
        add(0, 0, 0,    1, 0, 0,         0, 32'h100, 0, A2,  32'h8);
        add(0, 1, Dead, 1, 0, 0,         0, 32'h100, 0, A2,  32'h8);
        add(1, 0, 0,    1, 0, 0,         1, 32'h100, 0, A2,  32'h8);
        // redirect coincident with response
        add(0, 1, Bad,  1, 1, 32'h203,   0, 32'h104, 0, A2,  32'h8);
        // stray RValid in REQ is ignored; ungranted address stays stable
        add(0, 1, Dead, 1, 0, 0,         1, 32'h200, 0, A2,  32'h8);
        add(0, 0, 0,    1, 0, 0,         1, 32'h200, 0, A2,  32'h8);
        add(1, 0, 0,    1, 0, 0,         1, 32'h200, 0, A2,  32'h8);
        add(1, 1, C0,   1, 0, 0,         0, 32'h204, 0, A2,  32'h8);
        add(1, 0, 0,    0, 0, 0,         0, 32'h204, 1, C0,  32'h200);
        // redirect flushes a valid instruction even with decode stalled
        add(1, 0, 0,    0, 1, 32'h40,    0, 32'h204, 1, C0,  32'h200);
        add(1, 0, 0,    0, 0, 0,         1, 32'h40,  0, C0,  32'h200);

        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_req", {31'b0, req0}, 32'h0);
        chk("reset_valid", {31'b0, valid0}, 32'h0);
        chk("reset_instr", instr0, Nop);
        chk("reset_pcout", pcout0, 32'h0);
        chk("reset_addr", addr0, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].ready, vecs[i].redir,
                  vecs[i].rpc);
            #1;
            chk($sformatf("v%0d_req", i), {31'b0, req0}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), addr0, vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, valid0}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_instr", i), instr0, vecs[i].e_instr);
            chk($sformatf("v%0d_pcout", i), pcout0, vecs[i].e_pc);
            chk($sformatf("v%0d_pcp4", i), pcp40, vecs[i].e_pc + 32'd4);
            @(negedge clk);
        end

        // Reset with a request outstanding, then a stale response after release.
        drive(0, 0, 0, 1, 0, 0);
        reset = 1'b1;
        #1;
        chk("rst_wait_req", {31'b0, req0}, 32'h0);
        chk("rst_wait_valid", {31'b0, valid0}, 32'h0);
        chk("rst_wait_addr", addr0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, Bad, 1, 0, 0);
        #1;
        chk("stale_req", {31'b0, req0}, 32'h1);
        chk("stale_addr", addr0, 32'h0);
        @(negedge clk);
        chk("stale_valid", {31'b0, valid0}, 32'h0);
        chk("stale_instr", instr0, Nop);
        chk("stale_pcout", pcout0, 32'h0);

        // PC wrap from 0xFFFF_FFFC.
        drive(0, 0, 0, 1, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 1, 0, 0);
        #1;
        chk("wrap_req0", {31'b0, req1}, 32'h1);
        chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(1, 1, A0, 1, 0, 0);
        #1;
        chk("wrap_addr_mid", addr1, 32'h0);
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0);
        #1;
        chk("wrap_valid", {31'b0, valid1}, 32'h1);
        chk("wrap_pcout", pcout1, 32'hFFFF_FFFC);
        chk("wrap_pcp4", pcp41, 32'h0);
        chk("wrap_req1", {31'b0, req1}, 32'h1);
        chk("wrap_addr1", addr1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Port clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  in  1  asynchronous, active-high reset.
REQ-004 Port ImemReq  out  1  fetch request valid.
REQ-005 Port ImemAddr  out  32  fetch address; valid while ImemReq=1.
REQ-006 Port ImemGnt  in  1  memory accepts the request this cycle.
REQ-007 Port ImemRValid  in  1  read data valid.
REQ-008 Port ImemRData  in  32  fetched instruction word.
REQ-009 Port Redirect  in  1  taken branch or jump; flush the stage and restart fetch.
REQ-010 Port RedirectPC  in  32  new fetch PC; bits [1:0] ignored and treated as 0.
REQ-011 Port InstrValid  out  1  Instr, PCOut and PCPlus4 hold a valid instruction for decode.
REQ-012 Port InstrReady  in  1  decode consumes the instruction this cycle.
REQ-013 Port Instr  out  32  instruction to decode; Opcode=[6:0], Funct3=[14:12], Funct7Bit5=[30].
REQ-014 Port PCOut  out  32  address of Instr.
REQ-015 Port PCPlus4  out  32  PCOut+4, mod 2^32, for the link value.

Function
REQ-016 The stage SHALL have an FSM with states REQ (may issue), WAIT (one request outstanding) and DROP (outstanding response to discard).
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 ImemReq SHALL be 1 only when all hold: state=REQ, Redirect=0, reset=0, and (InstrValid=0 or InstrReady=1).
REQ-019 ImemAddr SHALL equal the fetch PC register whenever ImemReq=1.
REQ-020 On ImemReq&ImemGnt: fetch PC is captured into ReqPC, fetch PC becomes PC+4 (32-bit wrap, 0xFFFF_FFFC->0), and the state goes to WAIT.
REQ-021 On ImemReq=1 with ImemGnt=0, the state and PC SHALL hold; ImemAddr SHALL stay stable until the request is granted or a redirect occurs.
REQ-022 In WAIT, ImemRValid=1 and Redirect=0 SHALL load Instr=ImemRData, PCOut=ReqPC and InstrValid=1, and the state SHALL go to REQ.
REQ-023 ImemRValid SHALL be ignored in state REQ. The earliest response is the cycle after the grant.
REQ-024 Minimum latency: grant in cycle n, RValid in n+1, InstrValid=1 in n+2. Peak throughput is one instruction per 2 cycles.
REQ-025 The output buffer SHALL clear InstrValid on InstrValid&InstrReady, unless it is reloaded in the same cycle.
REQ-026 While InstrValid=1 and InstrReady=0, Instr and PCOut SHALL hold stable.
REQ-027 InstrReady SHALL be ignored while InstrValid=0.
REQ-028 Redirect=1 SHALL take priority over all other events.
REQ-029 On redirect, PC <= {RedirectPC[31:2],2'b00} and InstrValid <= 0 next cycle, regardless of InstrReady.
REQ-030 On redirect, no request SHALL be issued that cycle.
REQ-031 Redirect state transitions: REQ->REQ; WAIT with RValid=0 ->DROP; WAIT with RValid=1 ->REQ, data discarded; DROP->DROP.
REQ-032 In DROP, ImemRValid SHALL be discarded without touching the outputs, and the state SHALL go to REQ.
REQ-033 PCPlus4 SHALL be combinationally PCOut+4, wrapping mod 2^32.

Reset
REQ-034 While reset=1 (asynchronous): PC=RESET_PC, ReqPC=0, state=REQ, InstrValid=0, Instr=32'h0000_0013 (NOP), PCOut=0, ImemReq=0.
REQ-035 After reset is released, a stale ImemRValid from a request issued before reset SHALL be ignored, because the state is REQ.
REQ-036 The first request SHALL be issued in the first clock edge cycle after reset deassertion, with ImemAddr=RESET_PC.

Verification
REQ-037 Reset then constant ImemGnt=1, 1-cycle response, InstrReady=1 -> ImemAddr 0x0,0x4,0x8 on alternating cycles; PCOut sequence 0x0,0x4,0x8; PCPlus4 0x4,0x8,0xC.
REQ-038 Hold InstrReady=0 for 5 cycles with InstrValid=1 -> Instr/PCOut unchanged, no new ImemReq; InstrReady=1 -> next request issued in the same cycle.
REQ-039 Redirect to 0x100 while in WAIT, response arrives 2 cycles later -> response discarded (DROP), next ImemAddr=0x100, PCOut never shows the dropped word.
REQ-040 Redirect to 0x203 in the same cycle as ImemRValid -> data discarded, InstrValid=0, next ImemAddr=0x200.
REQ-041 RESET_PC=0xFFFF_FFFC, two fetches -> ImemAddr 0xFFFF_FFFC then 0x0; PCPlus4 of first=0x0.
REQ-042 Assert reset while in WAIT, then drive ImemRValid after release -> outputs stay at reset values and ImemAddr=RESET_PC.
